writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/riscv_pkg.sv | 15 +
 rtl/wb_fifo.sv | 74 +++++++
 rtl/writeback_arbiter.sv | 129 ++++++++++++
 tb/tb_writeback_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared core-wide definitions: data width, register-address width and the
// register-index type used by every block that touches the register file.
// No ports (package).
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 1 << REG_AW;

    typedef logic [REG_AW-1:0] reg_idx_t;

endpackage : riscv_pkg

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Small in-order buffer for completed load results awaiting the register
// file write port. Head entry is presented combinationally; pop advances it.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset (empties the buffer)
//   push       in   write push_data at the tail (ignored when full)
//   push_data  in   WIDTH-bit entry
//   pop        in   retire the head entry (ignored when empty)
//   head_data  out  current head entry
//   count      out  occupancy, 0..DEPTH
//   empty      out  no entries held
// ---------------------------------------------------------------------------
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];
    assign count     = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is data only; emptiness is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule : wb_fifo

// File: rtl/writeback_arbiter.sv
// ---------------------------------------------------------------------------
// writeback_arbiter
// Owns the single register-file write port. Single-cycle ALU results have
// strict priority and are never stalled; load results are buffered in a
// wb_fifo and drained whenever the ALU leaves the port free. A busy
// scoreboard tracks registers with outstanding loads for hazard queries.
//
// Ports
//   clk, rst_n                      clock / async active-low reset
//   alu_valid, alu_rd, alu_wd       ALU result (x0 results are dropped)
//   ld_issue, ld_issue_rd           load issued: marks rd busy
//   lsu_valid, lsu_ready            load-result handshake
//   lsu_rd, lsu_wd                  load-result destination / data
//   rf_we, rf_rd, rf_wd             registered register-file write port
//   rs1, rs2, rs1_busy, rs2_busy    scoreboard queries
//   lsu_count                       load buffer occupancy
// ---------------------------------------------------------------------------
module writeback_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN      = riscv_pkg::XLEN,
    parameter int LSU_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           alu_valid,
    input  reg_idx_t                       alu_rd,
    input  logic [XLEN-1:0]                alu_wd,
    input  logic                           ld_issue,
    input  reg_idx_t                       ld_issue_rd,
    input  logic                           lsu_valid,
    output logic                           lsu_ready,
    input  reg_idx_t                       lsu_rd,
    input  logic [XLEN-1:0]                lsu_wd,
    output logic                           rf_we,
    output reg_idx_t                       rf_rd,
    output logic [XLEN-1:0]                rf_wd,
    input  reg_idx_t                       rs1,
    input  reg_idx_t                       rs2,
    output logic                           rs1_busy,
    output logic                           rs2_busy,
    output logic [$clog2(LSU_DEPTH+1)-1:0] lsu_count
);

    localparam int CW = $clog2(LSU_DEPTH + 1);
    localparam int EW = REG_AW + XLEN;

    logic            alu_claim;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic [EW-1:0]   fifo_head;
    reg_idx_t        head_rd;
    logic [XLEN-1:0] head_wd;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    logic            rf_we_p1;
    reg_idx_t        rf_rd_p1;
    logic [XLEN-1:0] rf_wd_p1;

    // Gating with rst_n keeps ready low for the whole reset window, not just
    // until the first edge.
    assign lsu_ready = (lsu_count < CW'(LSU_DEPTH)) && rst_n;
    assign push      = lsu_valid && lsu_ready;

    // A write to x0 is a no-op, so it does not claim the port.
    assign alu_claim = alu_valid && (alu_rd != '0);
    assign pop       = !alu_claim && !fifo_empty;

    assign head_rd = fifo_head[XLEN +: REG_AW];
    assign head_wd = fifo_head[XLEN-1:0];

    wb_fifo #(
        .DEPTH (LSU_DEPTH),
        .WIDTH (EW)
    ) u_ld_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({lsu_rd, lsu_wd}),
        .pop       (pop),
        .head_data (fifo_head),
        .count     (lsu_count),
        .empty     (fifo_empty)
    );

    // Clear on pop first, then set on issue, so a re-issue to the same
    // register at the retiring edge keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        if (pop) busy_d[head_rd] = 1'b0;
        if (ld_issue && (ld_issue_rd != '0)) busy_d[ld_issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    assign rs1_busy = (rs1 != '0) && busy_q[rs1];
    assign rs2_busy = (rs2 != '0) && busy_q[rs2];

    // ---- stage p1: registered write port and scoreboard ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_p1 <= 1'b0;
            rf_rd_p1 <= '0;
            rf_wd_p1 <= '0;
            busy_q   <= '0;
        end else begin
            busy_q <= busy_d;
            if (alu_claim) begin
                rf_we_p1 <= 1'b1;
                rf_rd_p1 <= alu_rd;
                rf_wd_p1 <= alu_wd;
            end else if (pop && (head_rd != '0)) begin
                rf_we_p1 <= 1'b1;
                rf_rd_p1 <= head_rd;
                rf_wd_p1 <= head_wd;
            end else begin
                // Address/data hold; an x0 load is retired silently here.
                rf_we_p1 <= 1'b0;
            end
        end
    end

    assign rf_we = rf_we_p1;
    assign rf_rd = rf_rd_p1;
    assign rf_wd = rf_wd_p1;

endmodule : writeback_arbiter

// File: tb/tb_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// tb_writeback_arbiter
// Self-checking bench: directed scenarios plus randomized traffic, compared
// against a queue-based reference model of the write-port rules.
// ---------------------------------------------------------------------------
module tb_writeback_arbiter;

    localparam int XLEN      = 32;
    localparam int LSU_DEPTH = 2;

    logic              clk;
    logic              rst_n;
    logic              alu_valid;
    logic [4:0]        alu_rd;
    logic [XLEN-1:0]   alu_wd;
    logic              ld_issue;
    logic [4:0]        ld_issue_rd;
    logic              lsu_valid;
    logic              lsu_ready;
    logic [4:0]        lsu_rd;
    logic [XLEN-1:0]   lsu_wd;
    logic              rf_we;
    logic [4:0]        rf_rd;
    logic [XLEN-1:0]   rf_wd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic              rs1_busy;
    logic              rs2_busy;
    logic [1:0]        lsu_count;

    int n_checks = 0;
    int n_pass   = 0;

    writeback_arbiter #(
        .XLEN      (XLEN),
        .LSU_DEPTH (LSU_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_wd      (alu_wd),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_wd      (lsu_wd),
        .rf_we       (rf_we),
        .rf_rd       (rf_rd),
        .rf_wd       (rf_wd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .lsu_count   (lsu_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] wd;
    } ld_t;

    ld_t             m_q[$];
    bit              m_sb[32];
    logic            m_we;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_wd;

    function automatic bit m_ready();
        return m_q.size() < LSU_DEPTH;
    endfunction

    function automatic bit m_busy(input logic [4:0] r);
        return (r != 0) && m_sb[r];
    endfunction

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < 32; i++) m_sb[i] = 0;
        m_we = 1'b0;
        m_rd = '0;
        m_wd = '0;
    endtask

    // Advance model and DUT across one rising edge using the current inputs.
    task automatic step();
        bit  acc;
        bit  claim;
        bit  popn;
        ld_t head;
        ld_t e;
        acc   = lsu_valid && m_ready();
        claim = alu_valid && (alu_rd != 0);
        popn  = !claim && (m_q.size() > 0);
        m_we  = 1'b0;
        if (claim) begin
            m_we = 1'b1; m_rd = alu_rd; m_wd = alu_wd;
        end else if (popn) begin
            head = m_q.pop_front();
            m_sb[head.rd] = 0;
            if (head.rd != 0) begin
                m_we = 1'b1; m_rd = head.rd; m_wd = head.wd;
            end
        end
        if (ld_issue && ld_issue_rd != 0) m_sb[ld_issue_rd] = 1;
        if (acc) begin
            e.rd = lsu_rd; e.wd = lsu_wd;
            m_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_wd = '0;
        ld_issue = 1'b0; ld_issue_rd = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_wd = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        rs1 = 5'd0; rs2 = 5'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (rf_we !== 1'b0) $display("FAIL reset_we: got %0b want 0", rf_we); else n_pass++;
        n_checks++; if (rf_rd !== 5'd0) $display("FAIL reset_rd: got %0d want 0", rf_rd); else n_pass++;
        n_checks++; if (rf_wd !== 32'h0) $display("FAIL reset_wd: got %h want 0", rf_wd); else n_pass++;
        n_checks++; if (lsu_count !== 2'd0) $display("FAIL reset_count: got %0d want 0", lsu_count); else n_pass++;
        n_checks++; if (lsu_ready !== 1'b0) $display("FAIL reset_ready: got %0b want 0", lsu_ready); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (lsu_ready !== 1'b1) $display("FAIL reset_release_ready: got %0b want 1", lsu_ready); else n_pass++;
        step();
    endtask

    task automatic test_alu_basic();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_wd = 32'h0000000A;
        step();
        idle_inputs();
        n_checks++; if (rf_we !== 1'b1) $display("FAIL alu_we: got %0b want 1", rf_we); else n_pass++;
        n_checks++; if (rf_rd !== 5'd1) $display("FAIL alu_rd: got %0d want 1", rf_rd); else n_pass++;
        n_checks++; if (rf_wd !== 32'h0000000A) $display("FAIL alu_wd: got %h want 0000000a", rf_wd); else n_pass++;
        step();
        n_checks++; if (rf_we !== 1'b0) $display("FAIL alu_we_after: got %0b want 0", rf_we); else n_pass++;
        n_checks++; if (rf_rd !== 5'd1 || rf_wd !== 32'h0000000A)
            $display("FAIL alu_hold: got rd=%0d wd=%h want rd=1 wd=0000000a", rf_rd, rf_wd); else n_pass++;
    endtask

    task automatic test_alu_x0();
        // x0 result with nothing buffered: port stays idle.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_wd = 32'hFFFFFFFF;
        step();
        n_checks++; if (rf_we !== 1'b0) $display("FAIL x0_drop_we: got %0b want 0", rf_we); else n_pass++;
        // Buffer a load behind a real ALU write.
        alu_valid = 1'b1; alu_rd = 5'd9; alu_wd = 32'h00000099;
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_wd = 32'hCAFE0003;
        step();
        n_checks++; if (rf_rd !== 5'd9 || lsu_count !== 2'd1)
            $display("FAIL x0_setup: got rd=%0d count=%0d want rd=9 count=1", rf_rd, lsu_count); else n_pass++;
        // x0 result does not claim the port: the buffered load pops.
        lsu_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_wd = 32'hFFFFFFFF;
        step();
        idle_inputs();
        n_checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wd !== 32'hCAFE0003)
            $display("FAIL x0_pop: got we=%0b rd=%0d wd=%h want we=1 rd=3 wd=cafe0003", rf_we, rf_rd, rf_wd); else n_pass++;
        n_checks++; if (lsu_count !== 2'd0) $display("FAIL x0_pop_count: got %0d want 0", lsu_count); else n_pass++;
        step();
    endtask

    task automatic test_load_latency();
        ld_issue = 1'b1; ld_issue_rd = 5'd5;
        step();
        ld_issue = 1'b0;
        rs1 = 5'd5;
        #1;
        n_checks++; if (rs1_busy !== 1'b1) $display("FAIL ld_busy_set: got %0b want 1", rs1_busy); else n_pass++;
        lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_wd = 32'h12345678;
        step();                               // accept edge N
        lsu_valid = 1'b0;
        #1;
        n_checks++; if (rf_we !== 1'b0 || lsu_count !== 2'd1)
            $display("FAIL ld_after_accept: got we=%0b count=%0d want we=0 count=1", rf_we, lsu_count); else n_pass++;
        n_checks++; if (rs1_busy !== 1'b1) $display("FAIL ld_busy_hold: got %0b want 1", rs1_busy); else n_pass++;
        step();                               // pop edge N+1
        n_checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wd !== 32'h12345678)
            $display("FAIL ld_write: got we=%0b rd=%0d wd=%h want we=1 rd=5 wd=12345678", rf_we, rf_rd, rf_wd); else n_pass++;
        n_checks++; if (rs1_busy !== 1'b0) $display("FAIL ld_busy_clear: got %0b want 0", rs1_busy); else n_pass++;
        step();
    endtask

    task automatic test_backpressure();
        logic [4:0]      exp_rd[$];
        logic [XLEN-1:0] exp_wd[$];
        logic [4:0]      got_rd[$];
        logic [XLEN-1:0] got_wd[$];
        ld_t             loads[3];
        int              li;
        bit              saw_full;
        bit              acc;
        int              cnt_before;
        li = 0;
        saw_full = 0;
        for (int i = 0; i < 3; i++) begin
            loads[i].rd = 5'(11 + i);
            loads[i].wd = $urandom;
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc < 4) begin
                alu_valid = 1'b1; alu_rd = 5'(20 + cyc); alu_wd = $urandom;
                exp_rd.push_back(alu_rd); exp_wd.push_back(alu_wd);
            end else begin
                alu_valid = 1'b0;
            end
            lsu_valid = (li < 3);
            if (li < 3) begin lsu_rd = loads[li].rd; lsu_wd = loads[li].wd; end
            #1;
            n_checks++; if (lsu_ready !== m_ready())
                $display("FAIL bp_ready: cyc=%0d got %0b want %0b", cyc, lsu_ready, m_ready()); else n_pass++;
            if (lsu_count == 2'd2 && lsu_ready == 1'b0) saw_full = 1;
            acc = lsu_valid && lsu_ready;
            cnt_before = m_q.size();
            step();
            if (acc) li++;
            if (rf_we === 1'b1) begin got_rd.push_back(rf_rd); got_wd.push_back(rf_wd); end
            // Push and pop at the same edge leave occupancy unchanged.
            if (acc && cnt_before == 1 && cyc >= 4) begin
                n_checks++; if (lsu_count !== 2'd1)
                    $display("FAIL bp_pushpop_count: got %0d want 1", lsu_count); else n_pass++;
            end
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            exp_rd.push_back(loads[i].rd); exp_wd.push_back(loads[i].wd);
        end
        n_checks++; if (!saw_full) $display("FAIL bp_full_seen: got 0 want 1"); else n_pass++;
        n_checks++; if (li != 3) $display("FAIL bp_all_accepted: got %0d want 3", li); else n_pass++;
        n_checks++; if (got_rd.size() != exp_rd.size())
            $display("FAIL bp_write_count: got %0d want %0d", got_rd.size(), exp_rd.size()); else n_pass++;
        for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++) begin
            n_checks++; if (got_rd[i] !== exp_rd[i] || got_wd[i] !== exp_wd[i])
                $display("FAIL bp_order[%0d]: got rd=%0d wd=%h want rd=%0d wd=%h",
                         i, got_rd[i], got_wd[i], exp_rd[i], exp_wd[i]); else n_pass++;
        end
    endtask

    task automatic test_set_clear_same();
        ld_issue = 1'b1; ld_issue_rd = 5'd7;
        step();
        ld_issue = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_wd = 32'h22;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wd = 32'h77777777;
        step();
        idle_inputs();
        ld_issue = 1'b1; ld_issue_rd = 5'd7;  // re-issue at the pop edge
        rs2 = 5'd7;
        step();
        ld_issue = 1'b0;
        #1;
        n_checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd7)
            $display("FAIL sc_pop: got we=%0b rd=%0d want we=1 rd=7", rf_we, rf_rd); else n_pass++;
        n_checks++; if (rs2_busy !== 1'b1) $display("FAIL sc_set_wins: got %0b want 1", rs2_busy); else n_pass++;
        step();
    endtask

    task automatic test_reset_mid();
        ld_issue = 1'b1; ld_issue_rd = 5'd4;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_wd = 32'h1;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_wd = 32'h44;
        step();
        ld_issue_rd = 5'd6;
        lsu_rd = 5'd6; lsu_wd = 32'h66;
        step();
        idle_inputs();
        rs1 = 5'd4; rs2 = 5'd6;
        #1;
        n_checks++; if (lsu_count !== 2'd2 || rs1_busy !== 1'b1 || rs2_busy !== 1'b1)
            $display("FAIL rm_setup: got count=%0d b1=%0b b2=%0b want 2 1 1", lsu_count, rs1_busy, rs2_busy); else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (lsu_count !== 2'd0) $display("FAIL rm_count: got %0d want 0", lsu_count); else n_pass++;
        n_checks++; if (lsu_ready !== 1'b0) $display("FAIL rm_ready: got %0b want 0", lsu_ready); else n_pass++;
        n_checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0)
            $display("FAIL rm_busy: got %0b %0b want 0 0", rs1_busy, rs2_busy); else n_pass++;
        n_checks++; if (rf_we !== 1'b0) $display("FAIL rm_we: got %0b want 0", rf_we); else n_pass++;
        #4 rst_n = 1'b1;
        model_reset();
        #1;
        n_checks++; if (lsu_ready !== 1'b1) $display("FAIL rm_ready_after: got %0b want 1", lsu_ready); else n_pass++;
        step();
        n_checks++; if (rf_we !== 1'b0 || lsu_count !== 2'd0)
            $display("FAIL rm_idle: got we=%0b count=%0d want 0 0", rf_we, lsu_count); else n_pass++;
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            alu_valid   = ($urandom_range(0, 99) < 45);
            alu_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            alu_wd      = $urandom;
            ld_issue    = ($urandom_range(0, 99) < 30);
            ld_issue_rd = 5'($urandom_range(0, 31));
            lsu_valid   = ($urandom_range(0, 99) < 50);
            lsu_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            lsu_wd      = $urandom;
            rs1         = 5'($urandom_range(0, 31));
            rs2         = m_q.size() > 0 ? m_q[0].rd : 5'($urandom_range(0, 31));
            #1;
            n_checks++; if (lsu_ready !== m_ready())
                $display("FAIL rnd_ready: cyc=%0d got %0b want %0b", cyc, lsu_ready, m_ready()); else n_pass++;
            n_checks++; if (rs1_busy !== m_busy(rs1) || rs2_busy !== m_busy(rs2))
                $display("FAIL rnd_busy: cyc=%0d got %0b%0b want %0b%0b", cyc, rs1_busy, rs2_busy, m_busy(rs1), m_busy(rs2)); else n_pass++;
            step();
            n_checks++; if (rf_we !== m_we || rf_rd !== m_rd || rf_wd !== m_wd)
                $display("FAIL rnd_port: cyc=%0d got we=%0b rd=%0d wd=%h want we=%0b rd=%0d wd=%h",
                         cyc, rf_we, rf_rd, rf_wd, m_we, m_rd, m_wd); else n_pass++;
            n_checks++; if (lsu_count !== 2'(m_q.size()))
                $display("FAIL rnd_count: cyc=%0d got %0d want %0d", cyc, lsu_count, m_q.size()); else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_alu_basic();
        test_alu_x0();
        test_load_latency();
        test_backpressure();
        test_set_clear_same();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_writeback_arbiter
